// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 codes,
// FSM state encoding and the store-side lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_SB:   return 4'b0001 << a;
      F3_SH:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_SB:   return {4{data[7:0]}};
      F3_SH:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Unlisted funct3 codes behave as word accesses, so they need full alignment.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a,
                                         input logic is_load);
    logic half_acc;
    logic byte_acc;
    half_acc = (f3 == F3_LH) || (is_load && (f3 == F3_LHU));
    byte_acc = (f3 == F3_LB) || (is_load && (f3 == F3_LBU));
    if (byte_acc)
      return 1'b0;
    else if (half_acc)
      return a[0];
    else
      return a != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter: picks the addressed byte/half out of the returned
// word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Bytes above the top lane shift in as zeros for a half at offset 3.
  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data = {24'h000000, shifted[7:0]};
      F3_LHU:  data = {16'h0000, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: req/gnt + rvalid data bus master feeding MEM/WB.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] alu_result,
  input  logic [DW-1:0] store_data,
  input  logic [4:0]    rd,
  input  logic          reg_write,
  output logic          stall_o,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_wstrb,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic          wb_reg_write,
  output logic [DW-1:0] wb_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic          misalign_o
`endif
);

  lsu_state_t    state;
  logic          mem_op;
  logic          done;
  logic [DW-1:0] load_data;

  assign mem_op = mem_valid & (mem_read | mem_write);

  // EX/MEM is frozen while stalled, so funct3/rd/address stay valid through the access.
  assign done = ((state == REQ) & bus_gnt & bus_we) | ((state == RESP) & bus_rvalid);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (state == IDLE) & mem_op & is_misaligned(funct3, alu_result[1:0], mem_read);
  assign stall_o    = mem_op & ~done & ~misaligned;
`else
  assign stall_o    = mem_op & ~done;
`endif

  lsu_load_align u_load_align (
    .rdata   (bus_rdata),
    .addr_lo (alu_result[1:0]),
    .funct3  (funct3),
    .data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_wstrb    <= 4'b0000;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_o   <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_valid && !(mem_read || mem_write)) begin
            wb_valid     <= 1'b1;
            wb_rd        <= rd;
            wb_reg_write <= reg_write;
            wb_data      <= DW'(alu_result);
          end else if (mem_op) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned)
              misalign_o <= 1'b1;
            else
`endif
            begin
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {alu_result[AW-1:2], 2'b00};
              bus_wdata <= store_wdata(funct3, store_data);
              bus_wstrb <= mem_write ? store_strb(funct3, alu_result[1:0]) : 4'b0000;
              state     <= REQ;
            end
          end
        end

        REQ: begin
          if (bus_gnt) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= 4'b0000;
            if (bus_we) begin
              wb_valid     <= 1'b1;
              wb_rd        <= rd;
              wb_reg_write <= 1'b0;
              wb_data      <= DW'(alu_result);
              state        <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end

        RESP: begin
          if (bus_rvalid) begin
            wb_valid     <= 1'b1;
            wb_rd        <= rd;
            wb_reg_write <= reg_write;
            wb_data      <= load_data;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: scoreboard of MEM/WB results plus
// cycle-level checks of the bus request phase and stall_o.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        stall_o;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        chk_data;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   cyc = 0;

  mem_stage_lsu #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .rd           (rd),
    .reg_write    (reg_write),
    .stall_o      (stall_o),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .wb_data      (wb_data)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_o   (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    s = 4'b1111;
    if (f3 == 3'b000) begin
      s = 4'b0000;
      s[a] = 1'b1;
    end else if (f3 == 3'b001) begin
      s = a[1] ? 4'b1100 : 4'b0011;
    end
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'b000) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3 == 3'b001) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [7:0] lo;
    logic [7:0] hi;
    int idx;
    idx = int'(a);
    lo = w[8*idx +: 8];
    hi = (idx == 3) ? 8'h00 : w[8*(idx+1) +: 8];
    case (f3)
      3'b000:  return {{24{lo[7]}}, lo};
      3'b100:  return {24'h0, lo};
      3'b001:  return {{16{hi[7]}}, hi, lo};
      3'b101:  return {16'h0, hi, lo};
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      checkOutput("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checkOutput("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
        checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(mon_e.rw));
        if (mon_e.chk_data) checkOutput("wb_data", wb_data, mon_e.data);
        checkOutput("wb_latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
      end
    end
  end

  // Called just after a rising edge; returns just after the completing edge.
  task automatic applyStimulus(input logic is_rd, input logic is_wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] rd_i, input logic rw,
                               input int gnt_wait, input int rv_wait,
                               input logic [31:0] rdata);
    exp_t e;
    mem_valid  = 1'b1;
    mem_read   = is_rd;
    mem_write  = is_wr;
    funct3     = f3;
    alu_result = addr;
    store_data = sdata;
    rd         = rd_i;
    reg_write  = rw;
    e.rd       = rd_i;
    e.start    = cyc;
    e.data     = addr;
    e.chk_data = 1'b1;
    if (!is_rd && !is_wr) begin
      e.rw  = rw;
      e.lat = 1;
      sb_q.push_back(e);
      @(negedge clk);
      checkOutput("stall_alu", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (is_wr) begin
      e.rw       = 1'b0;
      e.chk_data = 1'b0;
      e.lat      = 2 + gnt_wait;
    end else begin
      e.rw   = rw;
      e.data = model_load(f3, addr[1:0], rdata);
      e.lat  = 3 + gnt_wait + rv_wait;
    end
    sb_q.push_back(e);
    @(negedge clk);
    checkOutput("stall_capture", 32'(stall_o), 32'd1);
    checkOutput("req_capture", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i <= gnt_wait; i++) begin
      bus_gnt    = (i == gnt_wait);
      bus_rvalid = is_rd && (i != gnt_wait);
      @(negedge clk);
      checkOutput("bus_req", 32'(bus_req), 32'd1);
      checkOutput("bus_we", 32'(bus_we), 32'(is_wr));
      checkOutput("bus_addr", bus_addr, {addr[31:2], 2'b00});
      checkOutput("bus_wstrb", 32'(bus_wstrb), is_wr ? 32'(model_strb(f3, addr[1:0])) : 32'd0);
      if (is_wr) checkOutput("bus_wdata", bus_wdata, model_wdata(f3, sdata));
      checkOutput("stall_req", 32'(stall_o), (is_wr && i == gnt_wait) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    if (is_rd) begin
      for (int i = 0; i <= rv_wait; i++) begin
        bus_rvalid = (i == rv_wait);
        bus_rdata  = (i == rv_wait) ? rdata : $urandom;
        @(negedge clk);
        checkOutput("req_resp", 32'(bus_req), 32'd0);
        checkOutput("stall_resp", 32'(stall_o), (i == rv_wait) ? 32'd0 : 32'd1);
        @(posedge clk); #1;
      end
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
    end
  endtask

  task automatic go_idle(input int n);
    mem_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checkOutput("stall_idle", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, "_bus_we"}, 32'(bus_we), 32'd0);
    checkOutput({tag, "_bus_addr"}, bus_addr, 32'd0);
    checkOutput({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    checkOutput({tag, "_bus_wstrb"}, 32'(bus_wstrb), 32'd0);
    checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    checkOutput({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    checkOutput({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'd0);
    checkOutput({tag, "_wb_data"}, wb_data, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    alu_result = 32'd0;
    store_data = 32'd0;
    rd         = 5'd0;
    reg_write  = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("reset_misalign", 32'(misalign_o), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 32'h0);
    applyStimulus(0, 0, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd7, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd9, 1, 2, 0, 32'h0);
    applyStimulus(1, 0, 3'b000, 32'h0000_0202, 32'h0, 5'd3, 1, 0, 1, 32'h0080_0000);
    applyStimulus(1, 0, 3'b100, 32'h0000_0202, 32'h0, 5'd4, 1, 0, 1, 32'h0080_0000);
    applyStimulus(1, 0, 3'b001, 32'h0000_0202, 32'h0, 5'd6, 1, 1, 0, 32'h8001_1234);
    applyStimulus(1, 0, 3'b101, 32'h0000_0200, 32'h0, 5'd8, 1, 0, 0, 32'h8001_F00D);
    applyStimulus(1, 0, 3'b010, 32'h0000_0404, 32'h0, 5'd10, 1, 0, 2, 32'hCAFE_BABE);
    applyStimulus(0, 1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 5'd11, 1, 1, 0, 32'h0);
    applyStimulus(0, 1, 3'b010, 32'h0000_0400, 32'h55AA_1234, 5'd12, 1, 0, 0, 32'h0);
    go_idle(2);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  f3r;
      logic [31:0] ar;
      f3r = (i % 2 == 0) ? 3'b000 : 3'b100;
      ar  = {20'h00001, 10'($urandom), 2'($urandom)};
      applyStimulus(1, 0, f3r, ar, 32'h0, 5'($urandom_range(1, 31)), 1,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end
    go_idle(2);

    // Reset while a load waits for its response.
    mem_valid  = 1'b1;
    mem_read   = 1'b1;
    funct3     = 3'b010;
    alu_result = 32'h0000_0500;
    rd         = 5'd13;
    reg_write  = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    mem_valid = 1'b0;
    mem_read  = 1'b0;
    @(negedge clk);
    check_all_zero("rst_resp");
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1111_2222;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("late_rvalid_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("late_rvalid_bus_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;

`ifdef LSU_MISALIGN_TRAP_EN
    mem_valid  = 1'b1;
    mem_read   = 1'b1;
    funct3     = 3'b001;
    alu_result = 32'h0000_0301;
    rd         = 5'd14;
    @(negedge clk);
    checkOutput("misalign_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_read  = 1'b0;
    @(negedge clk);
    checkOutput("misalign_pulse", 32'(misalign_o), 32'd1);
    checkOutput("misalign_bus_req", 32'(bus_req), 32'd0);
    checkOutput("misalign_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("misalign_clear", 32'(misalign_o), 32'd0);
    checkOutput("misalign_no_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
`endif

    go_idle(3);
    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit that consumes the EX/MEM register: `alu_result` as address, `store_data` as write data, plus `funct3` and writeback control. It drives a word-wide data bus with a req/gnt request phase and an rvalid response phase, and formats load data by byte lane and sign. It stalls the upstream pipeline while an access is in flight, then loads the MEM/WB register. Non-memory instructions pass through in one cycle.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; fixed at 32, four byte lanes

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `mem_valid`  in  1  EX/MEM holds a valid instruction
- `mem_read`  in  1  load
- `mem_write`  in  1  store; never set together with `mem_read`
- `funct3`  in  3  access size and sign
- `alu_result`  in  AW  address, or the result for non-memory instructions
- `store_data`  in  DW  rs2 value
- `rd`  in  5  destination register
- `reg_write`  in  1  writeback enable
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; combinational
- `bus_req`  out  1  request
- `bus_we`  out  1  1 = write
- `bus_addr`  out  AW  word-aligned address, low 2 bits are 0
- `bus_wdata`  out  DW  lane-replicated write data
- `bus_wstrb`  out  4  byte strobes; 0 for reads
- `bus_gnt`  in  1  request accepted
- `bus_rvalid`  in  1  read data valid
- `bus_rdata`  in  DW  read data
- `wb_valid`  out  1  MEM/WB valid
- `wb_rd`  out  5  MEM/WB destination register
- `wb_reg_write`  out  1  MEM/WB write enable
- `wb_data`  out  DW  load data or passed-through `alu_result`
- `misalign_o`  out  1  one-cycle misaligned-access pulse; exists only when `LSU_MISALIGN_TRAP_EN` is defined

## Operation
- **FSM states:** IDLE, REQ, RESP.
- **IDLE:**
  - `mem_valid & ~(mem_read|mem_write)`: load MEM/WB with `alu_result` at the clock edge. Stay in IDLE.
  - `mem_valid & (mem_read|mem_write)`: register `bus_addr`, `bus_we`, `bus_wdata` and `bus_wstrb`, then go to REQ.
  - `~mem_valid`: `wb_valid` is 0 next cycle.
- **REQ:**
  - `bus_req` is 1.
  - All bus outputs are held stable until `bus_gnt` is sampled high.
  - On gnt with a store: complete, load MEM/WB with `wb_reg_write`=0, go to IDLE.
  - On gnt with a load: go to RESP.
  - `bus_rvalid` is ignored in REQ.
- **RESP:**
  - `bus_req` is 0.
  - On `bus_rvalid`: load MEM/WB with the formatted `bus_rdata`, go to IDLE.
- **Stall:** `stall_o = mem_valid & (mem_read|mem_write) & ~done`.
  - `done` is the store-gnt term in REQ, or the rvalid term in RESP.
  - `stall_o` is 0 in the completing cycle, so EX/MEM advances on the same edge.
- **wb_valid:** is 0 on every edge where `stall_o` is 1. This inserts a bubble in WB.
- **Store encoding:**
  - SB (000): strb = `0001 << a[1:0]`, wdata = byte replicated to all four lanes.
  - SH (001): strb = `0011 << {a[1],0}`, wdata = half replicated to both halves.
  - SW (010): strb = `1111`.
- **Load formatting:**
  - LB (000), LH (001): select the lane by `a[1:0]`, sign-extend.
  - LW (010): full word.
  - LBU (100), LHU (101): select the lane, zero-extend.
  - Other `funct3` values are treated as LW/SW.
- **Reset:** takes priority over everything. State goes to IDLE even mid-access; an outstanding response is discarded.

## Timing
- **Reset values:**
  - `bus_req`, `bus_we`, `bus_wstrb`, `bus_addr` and `bus_wdata` are all 0.
  - `wb_valid`, `wb_rd`, `wb_reg_write` and `wb_data` are all 0.
  - `misalign_o` is 0.
- **Latency:**
  - Non-memory instruction: 1 cycle.
  - Store: minimum 2 cycles (capture, then gnt).
  - Load: minimum 3 cycles (capture, gnt, rvalid).
  - Each wait cycle on gnt or rvalid adds 1 cycle.
- Back-to-back memory ops: each new op starts in IDLE on the cycle after completion.
- `stall_o` contains no bus-input path, except through `bus_gnt` and `bus_rvalid` in the `done` term.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - A misaligned access is detected in IDLE: LH/LHU/SH with `a[0]`, or LW/SW with `a[1:0]`≠0.
  - No bus request is issued and the FSM stays in IDLE.
  - `misalign_o` pulses for 1 cycle and MEM/WB loads a bubble (`wb_valid`=0).
  - `stall_o` is 0 that cycle.
- **`LSU_MISALIGN_TRAP_EN` undefined:**
  - No detection, and no `misalign_o` port.
  - The access proceeds with the lane chosen from the low address bits as defined above; bits that spill past the word are dropped.

## Structure
- **Shared package `lsu_pkg`:**
  - `funct3` constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state encoding: IDLE, REQ, RESP.
- **Sub-module `lsu_load_align`:** combinational; takes `bus_rdata`, `a[1:0]` and `funct3`, returns `wb_data`.

## Test plan
- ADD result 0x0000_1234, rd=5, `reg_write`=1 → next cycle `wb_valid`=1, `wb_rd`=5, `wb_data`=0x0000_1234, `stall_o` never 1.
- SB, addr 0x103, data 0xAB, gnt held 0 for 2 cycles →
  - `bus_addr`=0x100, `bus_wstrb`=1000, `bus_wdata`=0xABABABAB, held stable.
  - `stall_o` stays 1 until the gnt cycle; `wb_reg_write`=0.
- LB, addr 0x202, rdata 0x0080_0000 after 1 wait cycle → `wb_data`=0xFFFF_FF80; LBU of the same → `wb_data`=0x0000_0080; total latency 4 cycles.
- LH at 0x301, with `LSU_MISALIGN_TRAP_EN` defined → `misalign_o` pulses once, `bus_req` stays 0, `wb_valid`=0.
- `rst_n`=0 while in RESP → next cycle state is IDLE and all outputs are 0; a later `bus_rvalid` is ignored.
